data_mem_responder: RTL and testbench

Word-organised data memory that answers the CPU's MEM-stage load/store port. It decodes the 4-bit read and 3-bit write commands, runs a fixed-latency access, and holds BUSYWAIT high until the access completes. It performs byte-lane merging for stores and byte/halfword extraction with sign or zero extension for loads. It sits between the CPU's DATA_MEM_* outputs and the top-level memory subsystem.

---
 rtl/mem_if_pkg.sv | 24 ++
 rtl/load_align_unit.sv | 28 ++
 rtl/data_mem_responder.sv | 186 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared encodings for the MEM-stage load/store command port.
// Used by both the CPU control unit and the data memory responder.
package mem_if_pkg;

  localparam int RD_EN_BIT = 3;
  localparam int WR_EN_BIT = 2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SZ_SB = 2'b00;
  localparam logic [1:0] SZ_SH = 2'b01;
  localparam logic [1:0] SZ_SW = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } mem_state_e;

endpackage

// File: rtl/load_align_unit.sv
// Combinational load extractor: picks the addressed byte/halfword of a word
// and sign- or zero-extends it according to the load funct3.
module load_align_unit
  import mem_if_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{byte_off, 3'b000} +: 8];
    half_sel = byte_off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LW:   result = word;
      F3_LBU:  result = {24'd0, byte_sel};
      F3_LHU:  result = {16'd0, half_sel};
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency word-organised data memory answering the CPU load/store port,
// with store byte-lane merging and extended loads.
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  DATA_MEM_READ,
  input  logic [2:0]  DATA_MEM_WRITE,
  input  logic [31:0] DATA_MEM_ADDR,
  input  logic [31:0] DATA_MEM_WRITE_DATA,
  output logic [31:0] DATA_MEM_READ_DATA,
  output logic        DATA_MEM_BUSYWAIT,
  output logic        DATA_MEM_ERROR
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] LOAD_CNT = 4'(LATENCY - 1);

  mem_state_e              state_reg, state_next;
  logic [3:0]              cnt_reg, cnt_next;
  logic [ADDR_WIDTH+1:0]   addr_reg, addr_next;
  logic [31:0]             wdata_reg, wdata_next;
  logic [3:0]              rd_cmd_reg, rd_cmd_next;
  logic [2:0]              wr_cmd_reg, wr_cmd_next;
  logic [31:0]             read_data_reg, read_data_next;
  logic                    err_reg, err_next;

  logic [31:0]             mem_array [0:DEPTH-1];
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [31:0]             word_rd;
  logic [31:0]             load_result;
  logic [31:0]             lane_data;
  logic [31:0]             merged_word;
  logic [3:0]              byte_en;
  logic                    mem_we;
  logic                    cmd_err;
  logic                    req;
  logic                    rd_en, wr_en;
  logic [1:0]              boff;

  // Upper address bits are deliberately dropped so addresses wrap modulo depth.
  logic addr_unused;
  assign addr_unused = &{1'b0, DATA_MEM_ADDR[31:ADDR_WIDTH+2]};

  assign req      = DATA_MEM_READ[RD_EN_BIT] | DATA_MEM_WRITE[WR_EN_BIT];
  assign rd_en    = rd_cmd_reg[RD_EN_BIT];
  assign wr_en    = wr_cmd_reg[WR_EN_BIT];
  assign boff     = addr_reg[1:0];
  assign word_idx = addr_reg[ADDR_WIDTH+1:2];
  assign word_rd  = mem_array[word_idx];

  load_align_unit u_load_align (
    .word     (word_rd),
    .byte_off (boff),
    .funct3   (rd_cmd_reg[2:0]),
    .result   (load_result)
  );

  always_comb begin
    cmd_err = 1'b0;
    if (rd_en && wr_en) begin
      cmd_err = 1'b1;
    end else if (rd_en) begin
      case (rd_cmd_reg[2:0])
        F3_LB, F3_LBU: cmd_err = 1'b0;
        F3_LH, F3_LHU: cmd_err = boff[0];
        F3_LW:         cmd_err = (boff != 2'b00);
        default:       cmd_err = 1'b1;
      endcase
    end else if (wr_en) begin
      case (wr_cmd_reg[1:0])
        SZ_SB:   cmd_err = 1'b0;
        SZ_SH:   cmd_err = boff[0];
        SZ_SW:   cmd_err = (boff != 2'b00);
        default: cmd_err = 1'b1;
      endcase
    end
  end

  // Store data is replicated across lanes so each lane can pick its own byte.
  always_comb begin
    byte_en   = 4'b0000;
    lane_data = wdata_reg;
    case (wr_cmd_reg[1:0])
      SZ_SB: begin
        byte_en   = 4'b0001 << boff;
        lane_data = {4{wdata_reg[7:0]}};
      end
      SZ_SH: begin
        byte_en   = boff[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata_reg[15:0]}};
      end
      SZ_SW:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_word[gi*8 +: 8] = byte_en[gi] ? lane_data[gi*8 +: 8]
                                                  : word_rd[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    rd_cmd_next    = rd_cmd_reg;
    wr_cmd_next    = wr_cmd_reg;
    read_data_next = read_data_reg;
    err_next       = err_reg;
    mem_we         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          addr_next   = DATA_MEM_ADDR[ADDR_WIDTH+1:0];
          wdata_next  = DATA_MEM_WRITE_DATA;
          rd_cmd_next = DATA_MEM_READ;
          wr_cmd_next = DATA_MEM_WRITE;
          cnt_next    = LOAD_CNT;
          state_next  = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_reg == 4'd0) begin
          // Commit point: the only place memory or READ_DATA change.
          state_next = ACK;
          err_next   = cmd_err;
          mem_we     = wr_en && !cmd_err;
          if (cmd_err) begin
            read_data_next = 32'd0;
          end else if (rd_en) begin
            read_data_next = load_result;
          end
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ACK: begin
        err_next   = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      addr_reg      <= '0;
      wdata_reg     <= 32'd0;
      rd_cmd_reg    <= 4'd0;
      wr_cmd_reg    <= 3'd0;
      read_data_reg <= 32'd0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      rd_cmd_reg    <= rd_cmd_next;
      wr_cmd_reg    <= wr_cmd_next;
      read_data_reg <= read_data_next;
      err_reg       <= err_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_array[word_idx] <= merged_word;
    end
  end

  assign DATA_MEM_BUSYWAIT  = RESET && (((state_reg == IDLE) && req) || (state_reg == ACCESS));
  assign DATA_MEM_READ_DATA = read_data_reg;
  assign DATA_MEM_ERROR     = err_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: expected results are queued when a
// request is driven and compared when the responder reaches its ACK cycle.
module tb_data_mem_responder;

  localparam int AW  = 10;
  localparam int LAT = 3;

  logic        CLK;
  logic        RESET;
  logic [3:0]  DATA_MEM_READ;
  logic [2:0]  DATA_MEM_WRITE;
  logic [31:0] DATA_MEM_ADDR;
  logic [31:0] DATA_MEM_WRITE_DATA;
  logic [31:0] DATA_MEM_READ_DATA;
  logic        DATA_MEM_BUSYWAIT;
  logic        DATA_MEM_ERROR;

  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .DATA_MEM_READ       (DATA_MEM_READ),
    .DATA_MEM_WRITE      (DATA_MEM_WRITE),
    .DATA_MEM_ADDR       (DATA_MEM_ADDR),
    .DATA_MEM_WRITE_DATA (DATA_MEM_WRITE_DATA),
    .DATA_MEM_READ_DATA  (DATA_MEM_READ_DATA),
    .DATA_MEM_BUSYWAIT   (DATA_MEM_BUSYWAIT),
    .DATA_MEM_ERROR      (DATA_MEM_ERROR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [3:0] C_LB  = 4'b1000, C_LH  = 4'b1001, C_LW = 4'b1010;
  localparam logic [3:0] C_LBU = 4'b1100, C_LHU = 4'b1101, C_L011 = 4'b1011;
  localparam logic [2:0] C_SB  = 3'b100,  C_SH  = 3'b101,  C_SW = 3'b110, C_S11 = 3'b111;

  typedef struct {
    string       tag;
    logic        chk_d;
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] rd, input logic [2:0] wr,
                       input logic [31:0] a, input logic [31:0] wd);
    DATA_MEM_READ       = rd;
    DATA_MEM_WRITE      = wr;
    DATA_MEM_ADDR       = a;
    DATA_MEM_WRITE_DATA = wd;
  endtask

  // Called with the DUT in the ACK cycle, sampled at the falling edge.
  task automatic pop_and_check();
    exp_t x;
    if (sb_q.size() == 0) begin
      check("scoreboard_underflow", 32'd1, 32'd0);
    end else begin
      x = sb_q.pop_front();
      check({x.tag, "_error"}, {31'd0, DATA_MEM_ERROR}, {31'd0, x.e});
      if (x.chk_d) check({x.tag, "_data"}, DATA_MEM_READ_DATA, x.d);
      $display("txn %s: rdata=%h err=%0b", x.tag, DATA_MEM_READ_DATA, DATA_MEM_ERROR);
    end
  endtask

  // Entered at posedge+1 with the DUT idle; leaves at posedge+1 of the cycle after ACK.
  task automatic txn(input string tag, input logic [3:0] rd, input logic [2:0] wr,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic chk_d, input logic [31:0] exp_d, input logic exp_e);
    int busy;
    sb_q.push_back('{tag, chk_d, exp_d, exp_e});
    drive(rd, wr, a, wd);
    busy = 0;
    @(negedge CLK);
    while (DATA_MEM_BUSYWAIT && busy < 40) begin
      busy++;
      @(negedge CLK);
    end
    check({tag, "_busy_cycles"}, 32'(busy), 32'(LAT + 1));
    pop_and_check();
    @(posedge CLK);
    #1 drive(4'd0, 3'd0, 32'd0, 32'd0);
  endtask

  initial begin
    logic [9:0] busy_vec;
    logic [9:0] exp_vec;
    logic [4:0] busy5;

    RESET = 1'b0;
    drive(C_LW, 3'd0, 32'h10, 32'd0);
    #12;
    check("reset_busy_forced_low", {31'd0, DATA_MEM_BUSYWAIT}, 32'd0);
    check("reset_read_data", DATA_MEM_READ_DATA, 32'd0);
    check("reset_error", {31'd0, DATA_MEM_ERROR}, 32'd0);
    drive(4'd0, 3'd0, 32'd0, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check("idle_no_request_busy", {31'd0, DATA_MEM_BUSYWAIT}, 32'd0);
    @(posedge CLK);
    #1;

    txn("sw_deadbeef", 4'd0, C_SW, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0, 1'b0);
    txn("lw_10",       C_LW, 3'd0, 32'h10, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0);
    txn("sb_80_11",    4'd0, C_SB, 32'h11, 32'h00000080, 1'b0, 32'd0, 1'b0);
    txn("lb_11",       C_LB, 3'd0, 32'h11, 32'd0, 1'b1, 32'hFFFFFF80, 1'b0);
    txn("lbu_11",      C_LBU, 3'd0, 32'h11, 32'd0, 1'b1, 32'h00000080, 1'b0);
    txn("lw_10_merged", C_LW, 3'd0, 32'h10, 32'd0, 1'b1, 32'hDEAD80EF, 1'b0);

    // Abort a store mid-ACCESS with reset; the word must survive.
    drive(4'd0, C_SW, 32'h10, 32'hFFFFFFFF);
    @(negedge CLK);
    @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    check("abort_busy_drop", {31'd0, DATA_MEM_BUSYWAIT}, 32'd0);
    check("abort_read_data_cleared", DATA_MEM_READ_DATA, 32'd0);
    drive(4'd0, 3'd0, 32'd0, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    txn("lw_after_abort", C_LW, 3'd0, 32'h10, 32'd0, 1'b1, 32'hDEAD80EF, 1'b0);

    txn("sh_1234_12", 4'd0, C_SH, 32'h12, 32'h00001234, 1'b0, 32'd0, 1'b0);
    txn("lhu_12",     C_LHU, 3'd0, 32'h12, 32'd0, 1'b1, 32'h00001234, 1'b0);
    txn("lh_13_misal", C_LH, 3'd0, 32'h13, 32'd0, 1'b1, 32'd0, 1'b1);
    txn("sh_8001_16", 4'd0, C_SH, 32'h16, 32'h00008001, 1'b0, 32'd0, 1'b0);
    txn("lh_16_neg",  C_LH, 3'd0, 32'h16, 32'd0, 1'b1, 32'hFFFF8001, 1'b0);
    txn("lw_10_sh",   C_LW, 3'd0, 32'h10, 32'd0, 1'b1, 32'h123480EF, 1'b0);

    txn("sw_misal_11",  4'd0, C_SW, 32'h11, 32'h0BADF00D, 1'b1, 32'd0, 1'b1);
    txn("both_enables", C_LW, C_SW, 32'h10, 32'h0BADF00D, 1'b1, 32'd0, 1'b1);
    txn("ld_f3_011",    C_L011, 3'd0, 32'h10, 32'd0, 1'b1, 32'd0, 1'b1);
    txn("st_size_11",   4'd0, C_S11, 32'h10, 32'h0BADF00D, 1'b1, 32'd0, 1'b1);
    txn("lw_10_unchanged", C_LW, 3'd0, 32'h10, 32'd0, 1'b1, 32'h123480EF, 1'b0);

    // Held load for 10 cycles: ACK in cycles 4 and 9, re-accepted after the IDLE gap.
    sb_q.push_back('{"held_lw_a", 1'b1, 32'h123480EF, 1'b0});
    sb_q.push_back('{"held_lw_b", 1'b1, 32'h123480EF, 1'b0});
    drive(C_LW, 3'd0, 32'h10, 32'd0);
    busy_vec = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      busy_vec[i] = DATA_MEM_BUSYWAIT;
      exp_vec[i]  = ((i % (LAT + 2)) != (LAT + 1));
      if (!DATA_MEM_BUSYWAIT) pop_and_check();
    end
    check("held_lw_busy_pattern", {22'd0, busy_vec}, {22'd0, exp_vec});
    check("held_lw_queue_drained", 32'(sb_q.size()), 32'd0);
    @(posedge CLK);
    #1 drive(4'd0, 3'd0, 32'd0, 32'd0);

    // Held store released right after its ACK: exactly one transaction.
    drive(4'd0, C_SW, 32'h20, 32'h55AA55AA);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      busy5[i] = DATA_MEM_BUSYWAIT;
    end
    check("held_sw_busy_pattern", {27'd0, busy5}, 32'b01111);
    @(posedge CLK);
    #1 drive(4'd0, 3'd0, 32'd0, 32'd0);
    @(negedge CLK);
    check("held_sw_no_retrigger", {31'd0, DATA_MEM_BUSYWAIT}, 32'd0);
    @(posedge CLK);
    #1;
    txn("lw_20", C_LW, 3'd0, 32'h20, 32'd0, 1'b1, 32'h55AA55AA, 1'b0);

    txn("lw_alias_1010", C_LW, 3'd0, 32'h1010, 32'd0, 1'b1, 32'h123480EF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
